// File: rtl/ram_bist_pkg.sv
// ============================================================================
// ram_bist_pkg : shared state encoding and default RAM geometry for the BIST
// Revision     : 1.0
// ============================================================================
`default_nettype none

package ram_bist_pkg;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 4;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } bist_state_e;
endpackage

`default_nettype wire

// File: rtl/ram_bist_cmp.sv
// ============================================================================
// ram_bist_cmp : registered read-back compare, saturating error count and
//                first-failing-address capture
// Revision     : 1.0
// ============================================================================
`default_nettype none

module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] expected,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  mismatch,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);
  localparam logic [ADDR_WIDTH:0] MAX_ERR = {1'b1, {ADDR_WIDTH{1'b0}}};

  assign mismatch = valid && (dout != expected);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      err_count       <= '0;
      first_fail_addr <= '0;
    end else if (mismatch) begin
      if (err_count == '0)
        first_fail_addr <= addr;
      if (err_count != MAX_ERR)
        err_count <= err_count + 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/ram_bist_ctrl.sv
// ============================================================================
// ram_bist_ctrl : write-seeded-pattern / read-compare BIST for a small RAM
// Revision      : 1.0
// ============================================================================
`default_nettype none

module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARTUP_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  mem_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_fail_addr
);
  localparam int                    WAIT_W    = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;
  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(STARTUP_WAIT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  bist_state_e           state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [DATA_WIDTH-1:0] seed_q;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  clear;
  logic                  mismatch;
  logic [DATA_WIDTH-1:0] exp_data;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [DATA_WIDTH-1:0] s,
                                                    input logic [ADDR_WIDTH-1:0] a);
    return s + DATA_WIDTH'(a);
  endfunction

  assign next_addr = addr + 1'b1;
  assign clear     = (state == S_IDLE) && start;
  assign exp_data  = pattern(seed_q, rd_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_WAIT;
      wait_cnt <= '0;
      addr     <= '0;
      seed_q   <= '0;
      rd_valid <= 1'b0;
      rd_addr  <= '0;
      mem_sel  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            ready <= 1'b1;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          mem_sel <= 1'b0;
          if (start) begin
            // First write is presented in the very next cycle
            seed_q   <= seed;
            pass     <= 1'b0;
            busy     <= 1'b1;
            addr     <= '0;
            mem_sel  <= 1'b1;
            mem_addr <= '0;
            mem_din  <= seed;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (addr == LAST_ADDR) begin
            addr     <= '0;
            mem_sel  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            state    <= S_READ;
          end else begin
            addr     <= next_addr;
            mem_addr <= next_addr;
            mem_din  <= pattern(seed_q, next_addr);
          end
        end
        S_READ: begin
          rd_valid <= 1'b1;
          rd_addr  <= addr;
          if (addr == LAST_ADDR) begin
            addr     <= '0;
            mem_addr <= '0;
            state    <= S_DRAIN;
          end else begin
            addr     <= next_addr;
            mem_addr <= next_addr;
          end
        end
        S_DRAIN: begin
          // The last compare lands on this edge, so fold it into pass directly
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == '0) && !mismatch;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_WAIT;
        end
      endcase
    end
  end

  ram_bist_cmp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .valid          (rd_valid),
    .addr           (rd_addr),
    .expected       (exp_data),
    .dout           (mem_dout),
    .mismatch       (mismatch),
    .err_count      (err_count),
    .first_fail_addr(first_fail_addr)
  );
endmodule

`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
// ============================================================================
// tb_ram_bist_ctrl : RAM model with stuck-at faults, cycle-indexed reference
//                    model, directed and randomized BIST runs
// Revision         : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_bist_ctrl;
  localparam int AW    = 2;
  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int SW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] seed;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          ready, busy, done, pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_fail_addr;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARTUP_WAIT(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .ready(ready), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_addr(first_fail_addr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM with registered read data and optional per-address stuck-at value
  logic [DW-1:0]    ram [DEPTH] = '{default: '0};
  logic [DEPTH-1:0] fault_en  = '0;
  logic [DW-1:0]    fault_val = '0;
  always @(posedge clk) begin
    if (mem_sel) ram[mem_addr] <= mem_din;
    else         mem_dout <= fault_en[mem_addr] ? fault_val : ram[mem_addr];
  end

  // Reference: m_n is the cycle index since acceptance (0 = idle, 10 = done)
  int m_n, m_wcnt, m_seed, m_err, m_ffa;
  bit m_ready, m_pass;

  function automatic int exp_word(input int s, input int a);
    return (s + a) % (1 << DW);
  endfunction

  function automatic int model_errs(input int s);
    int c = 0;
    for (int a = 0; a < DEPTH; a++)
      if (fault_en[a] && int'(fault_val) != exp_word(s, a)) c++;
    return (c > DEPTH) ? DEPTH : c;
  endfunction

  function automatic int model_ffa(input int s);
    for (int a = 0; a < DEPTH; a++)
      if (fault_en[a] && int'(fault_val) != exp_word(s, a)) return a;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ready <= 1'b0; m_wcnt <= 0; m_n <= 0; m_seed <= 0;
      m_err <= 0; m_ffa <= 0; m_pass <= 1'b0;
    end else if (!m_ready) begin
      m_wcnt <= m_wcnt + 1;
      if (m_wcnt + 1 == SW) m_ready <= 1'b1;
    end else if (m_n == 0) begin
      if (start) begin
        m_n <= 1; m_seed <= int'(seed); m_err <= 0; m_ffa <= 0; m_pass <= 1'b0;
      end
    end else if (m_n == 2 * DEPTH + 1) begin
      m_n    <= 2 * DEPTH + 2;
      m_err  <= model_errs(m_seed);
      m_ffa  <= model_ffa(m_seed);
      m_pass <= (model_errs(m_seed) == 0);
    end else if (m_n == 2 * DEPTH + 2) begin
      m_n <= 0;
    end else begin
      m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit w  = (m_n >= 1) && (m_n <= DEPTH);
      automatic bit r  = (m_n > DEPTH) && (m_n <= 2 * DEPTH);
      automatic int ea = w ? m_n - 1 : (r ? m_n - 1 - DEPTH : 0);
      chk("ready",    ready,    m_ready);
      chk("busy",     busy,     (m_n >= 1) && (m_n <= 2 * DEPTH + 1));
      chk("done",     done,     m_n == 2 * DEPTH + 2);
      chk("mem_sel",  mem_sel,  w);
      chk("mem_addr", mem_addr, ea);
      chk("mem_din",  mem_din,  w ? exp_word(m_seed, m_n - 1) : 0);
      if (m_n == 0 || m_n == 2 * DEPTH + 2) begin
        chk("err_count",       err_count,       m_err);
        chk("first_fail_addr", first_fail_addr, m_ffa);
        chk("pass",            pass,            m_pass);
      end else begin
        chk("pass_during_test", pass, 0);
        if (m_n <= DEPTH + 2) chk("err_count_early", err_count, 0);
      end
    end
  end

  int wlog[$];
  always @(negedge clk) if (mem_sel === 1'b1) wlog.push_back(int'(mem_addr) * 16 + int'(mem_din));

  task automatic wait_idle();
    int n = 0;
    while (!(ready && !busy && !done) && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) chk("idle_timeout", 0, 1);
  endtask

  // Launch a test; optionally poke start at cycle 'poke' or hold it from cycle 8
  task automatic run_test(input logic [DW-1:0] s, input int poke, input bit hold, output int lat);
    wait_idle();
    wlog.delete();
    start = 1'b1; seed = s;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      start = (hold && lat >= 8) ? 1'b1 : (lat == poke);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic chk_writes(input string nm, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_count"}, wlog.size(), 4);
    for (int i = 0; i < 4; i++) chk(nm, (i < wlog.size()) ? wlog[i] : -1, e[i]);
  endtask

  initial begin
    int lat, n;
    reset = 1'b1; start = 1'b0; seed = '0;
    @(negedge clk); chk_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {mem_sel, mem_addr, mem_din, ready, busy, done, pass, err_count, first_fail_addr}, 0);
    reset = 1'b0;

    // Startup: start during the wait period is ignored, ready after 4 cycles
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk); n++;
      start = (n == 2);
    end
    start = 1'b0;
    chk("ready_latency", n, 4);
    chk("early_start_ignored", busy, 0);

    run_test(4'h3, 0, 1'b0, lat);
    chk("done_latency", lat, 10);
    chk("clean_pass", pass, 1);
    chk("clean_err", err_count, 0);
    chk("clean_ffa", first_fail_addr, 0);
    chk_writes("clean_wr", 'h03, 'h14, 'h25, 'h36);

    run_test(4'hE, 0, 1'b0, lat);
    chk("wrap_pass", pass, 1);
    chk_writes("wrap_wr", 'h0E, 'h1F, 'h20, 'h31);

    fault_en = 4'b0100; fault_val = 4'h0;
    run_test(4'h3, 0, 1'b0, lat);
    chk("fault2_err", err_count, 1);
    chk("fault2_ffa", first_fail_addr, 2);
    chk("fault2_pass", pass, 0);

    fault_en = 4'b1111;
    run_test(4'h3, 0, 1'b0, lat);
    chk("stuck_err", err_count, 4);
    chk("stuck_ffa", first_fail_addr, 0);
    fault_en = '0;

    // Reset while writing address 1
    wait_idle();
    start = 1'b1; seed = 4'h5;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("abort_at_addr1", {mem_sel, mem_addr}, {1'b1, 2'd1});
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {mem_sel, mem_addr, mem_din, ready, busy, done, pass, err_count, first_fail_addr}, 0);
    reset = 1'b0;
    wait_ready(n);
    chk("abort_ready_latency", n, 4);

    // start while busy is ignored; the done pulse keeps its timing
    run_test(4'h9, 3, 1'b0, lat);
    chk("busy_poke_latency", lat, 10);

    // start held through DONE launches a second test from the IDLE cycle
    run_test(4'h1, 0, 1'b1, lat);
    chk("hold_latency", lat, 10);
    @(negedge clk);
    chk("hold_idle_busy", busy, 0);
    @(negedge clk);
    chk("hold_restart", {busy, mem_sel}, 2'b11);
    start = 1'b0;

    // Randomized runs, occasionally aborted by reset
    repeat (30) begin
      wait_idle();
      fault_en  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : '0;
      fault_val = 4'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        start = 1'b1; seed = 4'($urandom);
        @(negedge clk); start = 1'b0;
        repeat ($urandom_range(0, 9)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        wait_ready(n);
        chk("rand_ready_latency", n, 4);
      end else begin
        run_test(4'($urandom), $urandom_range(0, 9), 1'b0, lat);
        chk("rand_latency", lat, 10);
      end
    end

    repeat (15) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

`default_nettype wire
